// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback for the shared datapath.
// Optional performance counters are compiled in with `define PERF_COUNTER_EN.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15
`ifdef PERF_COUNTER_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       halted,
    output logic [1:0] error_code,
    output logic [2:0] state
`ifdef PERF_COUNTER_EN
    , output logic [CNT_W-1:0] cycle_count
    , output logic [CNT_W-1:0] instr_count
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [2:0] C_NONE  = 3'd0;
    localparam logic [2:0] C_RTYPE = 3'd1;
    localparam logic [2:0] C_LOAD  = 3'd2;
    localparam logic [2:0] C_STORE = 3'd3;
    localparam logic [2:0] C_BRAN  = 3'd4;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRAN  = 7'b1100011;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] class_q, class_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] err_q, err_d;

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        wait_d  = wait_q;
        err_d   = err_q;
        if (enable) begin
            case (state_q)
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    state_d = S_EXEC;
                    case (opcode)
                        OP_RTYPE: class_d = C_RTYPE;
                        OP_LOAD:  class_d = C_LOAD;
                        OP_STORE: class_d = C_STORE;
                        OP_BRAN:  class_d = C_BRAN;
                        default: begin
                            class_d = C_NONE;
                            state_d = S_HALT;
                            err_d   = 2'b01;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (class_q)
                        C_RTYPE:         state_d = S_WB;
                        C_LOAD, C_STORE: state_d = S_MEM;
                        C_BRAN:          state_d = S_FETCH;
                        default: begin
                            state_d = S_HALT;
                            err_d   = 2'b01;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_d  = 8'd0;
                        state_d = (class_q == C_LOAD) ? S_WB : S_FETCH;
                    end else if (wait_q == WAIT_LAST) begin
                        // The timeout edge itself leaves MEM, so the strobe is gone next cycle.
                        wait_d  = 8'd0;
                        state_d = S_HALT;
                        err_d   = 2'b10;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                S_WB:    state_d = S_FETCH;
                S_HALT:  state_d = S_HALT;
                default: state_d = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            class_q <= C_NONE;
            wait_q  <= 8'd0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Outputs come from state and latched class; only the branch decision looks at zero.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        halted     = 1'b0;
        error_code = 2'b00;
        state      = 3'd0;
        if (reset) begin
            state      = state_q;
            error_code = err_q;
            halted     = (state_q == S_HALT);
            case (state_q)
                S_FETCH: begin
                    ir_write = enable;
                    pc_write = enable;
                end
                S_EXEC: begin
                    alu_src = (class_q == C_LOAD) || (class_q == C_STORE);
                    if (class_q == C_RTYPE) begin
                        alu_op = 2'b10;
                    end else if (class_q == C_BRAN) begin
                        alu_op     = 2'b01;
                        pc_src     = zero;
                        pc_write   = zero && enable;
                        instr_done = enable;
                    end
                end
                S_MEM: begin
                    mem_read   = (class_q == C_LOAD);
                    mem_write  = (class_q == C_STORE) && enable;
                    instr_done = (class_q == C_STORE) && enable && mem_ready;
                end
                S_WB: begin
                    reg_write  = enable;
                    mem_to_reg = (class_q == C_LOAD);
                    instr_done = enable;
                end
                default: ;
            endcase
        end
    end

`ifdef PERF_COUNTER_EN
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (enable && (state_q != S_HALT)) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
        if (instr_done) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule
